regfile_wb_queue: RTL

REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

---
 rtl/regfile_wb_queue.sv | 114 +++++++++++
 1 files changed

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - writeback queue draining one write per cycle into a register file
// Optional read-data forwarding from queued entries: REGFILE_WB_QUEUE_FORWARD_EN.
module regfile_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    input  logic [4:0]  ctrl_readRegA,
    input  logic [4:0]  ctrl_readRegB,
    input  logic [31:0] data_readRegA,
    input  logic [31:0] data_readRegB,
    output logic [31:0] fwd_dataA,
    output logic [31:0] fwd_dataB,
    output logic        pendingA,
    output logic        pendingB,
    output logic [4:0]  count
);

    localparam int         PW   = $clog2(DEPTH);
    localparam logic [4:0] FULL = 5'(DEPTH);

    logic [4:0]    ent_reg  [DEPTH];
    logic [31:0]   ent_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [4:0]    count_q;
    logic          push;
    logic          pop;
    logic          match_a;
    logic          match_b;
    logic [PW-1:0] slot;

    assign wb_ready = (count_q != FULL) && !ctrl_reset;
    // Writes to r0 complete the handshake but never occupy a slot.
    assign push     = wb_valid && wb_ready && (wb_reg != 5'd0);
    assign pop      = (count_q != 5'd0);

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= 5'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + {4'd0, push} - {4'd0, pop};
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            ent_reg[wr_ptr]  <= wb_reg;
            ent_data[wr_ptr] <= wb_data;
        end
    end

    // The register file captures the head on the same edge that pops it.
    assign ctrl_writeEnable = pop && !ctrl_reset;
    assign ctrl_writeReg    = ctrl_writeEnable ? ent_reg[rd_ptr]  : 5'd0;
    assign data_writeReg    = ctrl_writeEnable ? ent_data[rd_ptr] : 32'd0;
    assign count            = count_q;

`ifdef REGFILE_WB_QUEUE_FORWARD_EN
    logic [31:0] hit_a;
    logic [31:0] hit_b;
`endif

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        match_a = 1'b0;
        match_b = 1'b0;
        slot    = '0;
`ifdef REGFILE_WB_QUEUE_FORWARD_EN
        hit_a   = 32'd0;
        hit_b   = 32'd0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + PW'(i);
            if (5'(i) < count_q) begin
                if (ctrl_readRegA != 5'd0 && ent_reg[slot] == ctrl_readRegA) begin
                    match_a = 1'b1;
`ifdef REGFILE_WB_QUEUE_FORWARD_EN
                    hit_a   = ent_data[slot];
`endif
                end
                if (ctrl_readRegB != 5'd0 && ent_reg[slot] == ctrl_readRegB) begin
                    match_b = 1'b1;
`ifdef REGFILE_WB_QUEUE_FORWARD_EN
                    hit_b   = ent_data[slot];
`endif
                end
            end
        end
    end

    assign pendingA = match_a && !ctrl_reset;
    assign pendingB = match_b && !ctrl_reset;

`ifdef REGFILE_WB_QUEUE_FORWARD_EN
    assign fwd_dataA = pendingA ? hit_a : data_readRegA;
    assign fwd_dataB = pendingB ? hit_b : data_readRegB;
`else
    assign fwd_dataA = data_readRegA;
    assign fwd_dataB = data_readRegB;
`endif

endmodule
